// File: rtl/ext_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ext_irq_ctrl_if
// Description : Single-cycle MMIO register port of the external-interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ext_irq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            bus_valid;
    logic            bus_we;
    logic [11:0]     bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_rvalid;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/ext_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ext_irq_ctrl
// Description : Level-gateway external-interrupt controller with per-hart
//               priority/threshold arbitration and MMIO claim/complete.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_irq_ctrl #(
    parameter int NUM_SRC   = 8,
    parameter int NUM_HARTS = 4,
    parameter int PRIO_W    = 3,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   irq_src_i,
    ext_irq_ctrl_if.slave        bus,
    output logic [NUM_HARTS-1:0] meip_o
);
    localparam int ID_W = $clog2(NUM_SRC + 1);

    logic [PRIO_W-1:0]  prio_q  [1:NUM_SRC];
    logic [PRIO_W-1:0]  prio_d  [1:NUM_SRC];
    logic [NUM_SRC:1]   en_q    [NUM_HARTS];
    logic [NUM_SRC:1]   en_d    [NUM_HARTS];
    logic [PRIO_W-1:0]  thr_q   [NUM_HARTS];
    logic [PRIO_W-1:0]  thr_d   [NUM_HARTS];
    logic [NUM_SRC:1]   pend_q, pend_d;
    logic [NUM_SRC:1]   insvc_q, insvc_d;
    logic [NUM_HARTS-1:0] meip_q, meip_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               rvalid_q;

    logic [NUM_SRC:1]   w_elig     [NUM_HARTS];
    logic [ID_W-1:0]    w_claim_id [NUM_HARTS];
    logic [PRIO_W-1:0]  w_best     [NUM_HARTS];
    logic [NUM_SRC:1]   w_irq;
    logic [11:0]        w_addr;
    logic [XLEN-1:0]    w_wdata;
    logic               w_rd, w_wr, w_is_prio, w_is_hart;
    logic [XLEN-1:0]    w_rval;

    assign w_irq     = irq_src_i;
    assign w_addr    = bus.bus_addr;
    assign w_wdata   = bus.bus_wdata;
    assign w_rd      = bus.bus_valid & ~bus.bus_we;
    assign w_wr      = bus.bus_valid & bus.bus_we;
    assign w_is_prio = (w_addr[11:7] == 5'd0) && (w_addr[1:0] == 2'd0);
    assign w_is_hart = (w_addr[11:8] == 4'h1);

    // Strict '>' on priority keeps the lowest id among equal-priority winners.
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_elig[h]     = '0;
            w_claim_id[h] = '0;
            w_best[h]     = '0;
            for (int i = 1; i <= NUM_SRC; i++) begin
                w_elig[h][i] = pend_q[i] & en_q[h][i] & (prio_q[i] > thr_q[h]);
                if (w_elig[h][i] && (prio_q[i] > w_best[h])) begin
                    w_best[h]     = prio_q[i];
                    w_claim_id[h] = ID_W'(i);
                end
            end
            meip_d[h] = |w_elig[h];
        end
    end

    always_comb begin
        prio_d  = prio_q;
        en_d    = en_q;
        thr_d   = thr_q;
        insvc_d = insvc_q;
        pend_d  = pend_q | (w_irq & ~insvc_q);
        w_rval  = '0;

        for (int i = 1; i <= NUM_SRC; i++) begin
            if (w_is_prio && (w_addr[6:2] == 5'(i))) begin
                w_rval = XLEN'(prio_q[i]);
                if (w_wr) prio_d[i] = w_wdata[PRIO_W-1:0];
            end
        end

        if (w_addr == 12'h080) w_rval = XLEN'({pend_q, 1'b0});

        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_is_hart && (w_addr[7:4] == 4'(h))) begin
                case (w_addr[3:0])
                    4'h0: begin
                        w_rval = XLEN'({en_q[h], 1'b0});
                        if (w_wr) en_d[h] = w_wdata[NUM_SRC:1];
                    end
                    4'h4: begin
                        w_rval = XLEN'(thr_q[h]);
                        if (w_wr) thr_d[h] = w_wdata[PRIO_W-1:0];
                    end
                    4'h8: begin
                        w_rval = XLEN'(w_claim_id[h]);
                        // Claim overrides the gateway set computed above.
                        for (int i = 1; i <= NUM_SRC; i++) begin
                            if (w_rd && (w_claim_id[h] == ID_W'(i))) begin
                                pend_d[i]  = 1'b0;
                                insvc_d[i] = 1'b1;
                            end
                            if (w_wr && (w_wdata == XLEN'(i))) insvc_d[i] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        rdata_d = w_rd ? w_rval : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                en_q[h]  <= '0;
                thr_q[h] <= '0;
            end
            pend_q   <= '0;
            insvc_q  <= '0;
            meip_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            en_q     <= en_d;
            thr_q    <= thr_d;
            pend_q   <= pend_d;
            insvc_q  <= insvc_d;
            meip_q   <= meip_d;
            rdata_q  <= rdata_d;
            rvalid_q <= w_rd;
        end
    end

    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;
    assign meip_o         = meip_q;
endmodule
`default_nettype wire
